// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the branch redirect unit: condition codes, FSM encoding, default widths.
// Also imported by any later early-resolve logic that reuses branch_cond_eval.
package branch_redirect_unit_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_t;

endpackage

// File: rtl/branch_redirect_unit_cond_eval.sv
// Combinational taken decode from funct3 and the ALU zero/pos flags.
// Undefined condition codes resolve as not taken.
module branch_cond_eval
   import branch_redirect_unit_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       pos,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = ~zero;
         F3_BLT:  taken = ~pos & ~zero;
         F3_BGE:  taken = pos | zero;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_redirect_unit.sv
// Registered branch resolve: holds a redirect to fetch under valid/ready and flushes IF/ID, ID/EX until accepted.
// Optional saturating branch/taken counters when BRANCH_STATS_EN is defined.
module branch_redirect_unit
   import branch_redirect_unit_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int STAT_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_stall,
   input  logic            branch,
   input  logic [2:0]      funct3,
   input  logic            zero,
   input  logic            pos,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            if_ready,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush_ifid,
   output logic            flush_idex,
   output logic            busy,
   output logic            misalign
`ifdef BRANCH_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_taken
`endif
);

   state_t          state, state_next;
   logic            taken;
   logic            eval;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_q;
   logic            misalign_q;

   branch_cond_eval u_cond_eval (
      .funct3 (funct3),
      .zero   (zero),
      .pos    (pos),
      .taken  (taken)
   );

   // EX inputs are wrong-path while a redirect is pending, so evaluation is gated on IDLE.
   assign eval   = ex_valid & branch & ~ex_stall & (state == IDLE);
   assign target = ex_pc + ex_imm;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (eval && taken) state_next = REDIRECT;
         REDIRECT: if (if_ready)      state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // redirect_pc only loads from IDLE, so it is stable for the whole REDIRECT hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         if (eval && taken) begin
            pc_q       <= {target[XLEN-1:1], 1'b0};
            misalign_q <= target[1];
         end
      end
   end

   assign redirect_valid = (state == REDIRECT);
   assign busy           = (state == REDIRECT);
   assign flush_ifid     = (state == REDIRECT);
   assign flush_idex     = (state == REDIRECT);
   assign redirect_pc    = pc_q;
   assign misalign       = misalign_q;

`ifdef BRANCH_STATS_EN
   localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
   logic [STAT_W-1:0] br_cnt, tk_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt <= '0;
         tk_cnt <= '0;
      end else begin
         if (eval && (br_cnt != '1))          br_cnt <= br_cnt + STAT_ONE;
         if (eval && taken && (tk_cnt != '1)) tk_cnt <= tk_cnt + STAT_ONE;
      end
   end

   assign stat_branches = br_cnt;
   assign stat_taken    = tk_cnt;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit; redirect targets are queued at issue and popped when redirect_valid rises.
// Build with BRANCH_STATS_EN defined to also exercise the counters (narrowed to 3 bits for saturation).
module tb_branch_redirect_unit;

   localparam int XLEN   = 32;
   localparam int STAT_W = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ex_valid, ex_stall, branch, zero, pos, if_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] ex_pc, ex_imm;
   logic            redirect_valid, flush_ifid, flush_idex, busy, misalign;
   logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
   logic [STAT_W-1:0] stat_branches, stat_taken;
`endif

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned failed = 0;

   logic [XLEN-1:0] exp_q[$];
   logic [XLEN-1:0] cur_exp;
   logic            prev_v = 1'b0;

   always #5 clk = ~clk;

   branch_redirect_unit #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_stall       (ex_stall),
      .branch         (branch),
      .funct3         (funct3),
      .zero           (zero),
      .pos            (pos),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .if_ready       (if_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_ifid     (flush_ifid),
      .flush_idex     (flush_idex),
      .busy           (busy),
      .misalign       (misalign)
`ifdef BRANCH_STATS_EN
      ,
      .stat_branches  (stat_branches),
      .stat_taken     (stat_taken)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard pop on the first redirect cycle; held cycles must keep the same target.
   task automatic tick();
      @(posedge clk);
      #1;
      if (redirect_valid === 1'b1 && prev_v !== 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_redirect", 64'(redirect_pc), 64'hDEAD);
         end else begin
            cur_exp = exp_q.pop_front();
            chk("sb_redirect_pc", 64'(redirect_pc), 64'(cur_exp));
         end
      end else if (redirect_valid === 1'b1) begin
         chk("sb_pc_held", 64'(redirect_pc), 64'(cur_exp));
      end
      prev_v = redirect_valid;
   endtask

   task automatic drive(input logic [2:0] f3, input logic z, input logic p,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
      ex_valid = 1'b1; branch = 1'b1; ex_stall = 1'b0;
      funct3 = f3; zero = z; pos = p; ex_pc = pc; ex_imm = imm;
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; branch = 1'b0; ex_stall = 1'b0;
      funct3 = 3'b000; zero = 1'b0; pos = 1'b0;
   endtask

   function automatic logic [XLEN-1:0] tgt(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
      logic [XLEN-1:0] t;
      t = pc + imm;
      t[0] = 1'b0;
      return t;
   endfunction

   task automatic chk_outs(input string tag, input logic v);
      chk({tag, "_valid"}, 64'(redirect_valid), 64'(v));
      chk({tag, "_flush_ifid"}, 64'(flush_ifid), 64'(v));
      chk({tag, "_flush_idex"}, 64'(flush_idex), 64'(v));
      chk({tag, "_busy"}, 64'(busy), 64'(v));
   endtask

   // One branch with fetch ready; a taken one redirects for exactly one cycle.
   task automatic branch_op(input string tag, input logic [2:0] f3, input logic z, input logic p,
                            input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic exp_taken);
      if_ready = 1'b1;
      drive(f3, z, p, pc, imm);
      if (exp_taken) exp_q.push_back(tgt(pc, imm));
      tick();
      idle_inputs();
      chk_outs(tag, exp_taken);
      tick();
      chk({tag, "_after"}, 64'(redirect_valid), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; if_ready = 1'b0; ex_pc = '0; ex_imm = '0;
      idle_inputs();
      tick(); tick();
      chk_outs("reset", 1'b0);
      chk("reset_pc", 64'(redirect_pc), 64'd0);
      chk("reset_misalign", 64'(misalign), 64'd0);
      rst_n = 1'b1;
      tick();

      branch_op("beq_taken", 3'b000, 1'b1, 1'b0, 32'h100, 32'h20, 1'b1);
      branch_op("bne_zero", 3'b001, 1'b1, 1'b0, 32'h100, 32'h20, 1'b0);
      branch_op("blt_neg_imm", 3'b100, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFF0, 1'b1);
      branch_op("blt_pos", 3'b100, 1'b0, 1'b1, 32'h100, 32'h40, 1'b0);
      branch_op("bge_zero", 3'b101, 1'b1, 1'b0, 32'h180, 32'h11, 1'b1);
      branch_op("f3_010", 3'b010, 1'b1, 1'b1, 32'h100, 32'h40, 1'b0);
      branch_op("wrap", 3'b001, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h20, 1'b1);

      // Taken-looking condition on a non-branch instruction.
      if_ready = 1'b1;
      drive(3'b000, 1'b1, 1'b0, 32'h100, 32'h8);
      branch = 1'b0;
      tick();
      idle_inputs();
      chk_outs("non_branch", 1'b0);

      // Backpressure: held four cycles while a second taken branch is presented.
      if_ready = 1'b0;
      drive(3'b101, 1'b0, 1'b1, 32'h200, 32'h40);
      exp_q.push_back(tgt(32'h200, 32'h40));
      tick();
      drive(3'b000, 1'b1, 1'b0, 32'h300, 32'h4);
      for (int k = 1; k <= 4; k++) begin
         chk_outs($sformatf("bp_hold%0d", k), 1'b1);
         chk($sformatf("bp_pc%0d", k), 64'(redirect_pc), 64'h240);
         if_ready = (k == 4);
         tick();
      end
      idle_inputs();
      chk_outs("bp_release", 1'b0);
      tick();
      chk("bp_no_second", 64'(redirect_valid), 64'd0);

      // Stall blocks evaluation; released stall redirects the following cycle.
      if_ready = 1'b1;
      drive(3'b000, 1'b1, 1'b0, 32'h400, 32'h10);
      ex_stall = 1'b1;
      tick();
      chk_outs("stall", 1'b0);
      ex_stall = 1'b0;
      exp_q.push_back(tgt(32'h400, 32'h10));
      tick();
      idle_inputs();
      chk_outs("unstall", 1'b1);
      tick();
      chk("unstall_done", 64'(redirect_valid), 64'd0);

      // Asynchronous reset in the middle of a redirect.
      if_ready = 1'b0;
      drive(3'b000, 1'b1, 1'b0, 32'h500, 32'h8);
      exp_q.push_back(tgt(32'h500, 32'h8));
      tick();
      idle_inputs();
      chk("mid_redirect", 64'(redirect_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_outs("async_rst", 1'b0);
      chk("async_rst_pc", 64'(redirect_pc), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_outs("post_rst", 1'b0);

      // Target with bit1 set: misalign for one cycle only, redirect proceeds.
      if_ready = 1'b0;
      drive(3'b000, 1'b1, 1'b0, 32'h100, 32'h2);
      exp_q.push_back(tgt(32'h100, 32'h2));
      tick();
      idle_inputs();
      chk("misalign_pulse", 64'(misalign), 64'd1);
      chk("misalign_pc", 64'(redirect_pc), 64'h102);
      tick();
      chk("misalign_clear", 64'(misalign), 64'd0);
      chk("misalign_still_valid", 64'(redirect_valid), 64'd1);
      if_ready = 1'b1;
      tick();
      chk("misalign_done", 64'(redirect_valid), 64'd0);

`ifdef BRANCH_STATS_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("stat_reset_b", 64'(stat_branches), 64'd0);
      branch_op("st1", 3'b000, 1'b1, 1'b0, 32'h100, 32'h4, 1'b1);
      branch_op("st2", 3'b001, 1'b1, 1'b0, 32'h100, 32'h4, 1'b0);
      branch_op("st3", 3'b100, 1'b0, 1'b0, 32'h100, 32'h8, 1'b1);
      branch_op("st4", 3'b101, 1'b0, 1'b0, 32'h100, 32'h8, 1'b0);
      branch_op("st5", 3'b101, 1'b0, 1'b1, 32'h100, 32'hC, 1'b1);
      chk("stat_branches5", 64'(stat_branches), 64'd5);
      chk("stat_taken3", 64'(stat_taken), 64'd3);
      for (int i = 0; i < 5; i++)
         branch_op("st_sat", 3'b000, 1'b1, 1'b0, 32'h100, 32'h10, 1'b1);
      chk("stat_branches_sat", 64'(stat_branches), 64'd7);
      chk("stat_taken_sat", 64'(stat_taken), 64'd7);
`endif

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
